// File: rtl/adec_pkg.sv
// Shared constants for the programmable address decoder: reset window map,
// config field layout, ctrl-bit positions and FSM state encoding.
package adec_pkg;

  localparam int MAX_CS = 8;

  localparam logic [15:0] IO_HOLE_BASE = 16'hD000;
  localparam logic [15:0] IO_HOLE_MASK = 16'hF000;

  // Reset map: SID, VIA1, VIA2, UART, bifrost (off), spares (off)
  localparam logic [15:0] DEF_BASE [MAX_CS] = '{16'hD400, 16'hDC00, 16'hDC10, 16'hDC20,
                                                16'hDE00, 16'h0000, 16'h0000, 16'h0000};
  localparam logic [15:0] DEF_MASK [MAX_CS] = '{16'hFC00, 16'hFFF0, 16'hFFF0, 16'hFFF0,
                                                16'hFE00, 16'hFFFF, 16'hFFFF, 16'hFFFF};
  localparam logic [7:0]  DEF_CTRL [MAX_CS] = '{8'h80, 8'h80, 8'h80, 8'h80,
                                                8'h00, 8'h00, 8'h00, 8'h00};

  localparam logic [2:0] FLD_BASE_LO = 3'd0;
  localparam logic [2:0] FLD_BASE_HI = 3'd1;
  localparam logic [2:0] FLD_MASK_LO = 3'd2;
  localparam logic [2:0] FLD_MASK_HI = 3'd3;
  localparam logic [2:0] FLD_CTRL    = 3'd4;

  localparam int CTRL_EN_BIT = 7;
  localparam int CTRL_WP_BIT = 6;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_WAIT = 1'b1;

endpackage

// File: rtl/adec_window.sv
// One decode channel: base/mask/ctrl registers written from the config port
// and a combinational window match against the current CPU address.
module adec_window
  import adec_pkg::*;
#(
  parameter int CH     = 0,
  parameter int WAIT_W = 3
) (
  input  logic              clock,
  input  logic              reset_b,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_field,
  input  logic [7:0]        cfg_data,
  input  logic [15:0]       addr_lo,
  input  logic              bank_zero,
  input  logic              rw,
  output logic              match,
  output logic [WAIT_W-1:0] wait_cnt
);

  logic [15:0]       base;
  logic [15:0]       mask;
  logic              en;
  logic              wp;
  logic [WAIT_W-1:0] wt;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      base <= DEF_BASE[CH];
      mask <= DEF_MASK[CH];
      en   <= DEF_CTRL[CH][CTRL_EN_BIT];
      wp   <= DEF_CTRL[CH][CTRL_WP_BIT];
      wt   <= DEF_CTRL[CH][WAIT_W-1:0];
    end else if (cfg_we) begin
      case (cfg_field)
        FLD_BASE_LO: base[7:0]  <= cfg_data;
        FLD_BASE_HI: base[15:8] <= cfg_data;
        FLD_MASK_LO: mask[7:0]  <= cfg_data;
        FLD_MASK_HI: mask[15:8] <= cfg_data;
        FLD_CTRL: begin
          en <= cfg_data[CTRL_EN_BIT];
          wp <= cfg_data[CTRL_WP_BIT];
          wt <= cfg_data[WAIT_W-1:0];
        end
        default: ;
      endcase
    end
  end

  // A write-protected window simply does not claim writes.
  assign match = en && bank_zero && (((addr_lo ^ base) & mask) == 16'h0000) && !(wp && !rw);
  assign wait_cnt = wt;

endmodule

// File: rtl/adec_prog.sv
// Programmable registered address decoder: priority-encodes the channel
// windows, registers the selects and stretches slow accesses via rdy.
module adec_prog
  import adec_pkg::*;
#(
  parameter int NUM_CS = 6,
  parameter int ADDR_W = 19,
  parameter int WAIT_W = 3
) (
  input  logic              clock,
  input  logic              reset_b,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic              cfg_we,
  input  logic [5:0]        cfg_addr,
  input  logic [7:0]        cfg_data,
  output logic [NUM_CS-1:0] cs_b,
  output logic              ram_cs_b,
  output logic              rdy
);

  logic              bank_zero;
  logic [NUM_CS-1:0] match;
  logic [WAIT_W-1:0] wait_all [NUM_CS];

  assign bank_zero = (addr[ADDR_W-1:16] == '0);

  for (genvar i = 0; i < NUM_CS; i++) begin : g_win
    adec_window #(.CH(i), .WAIT_W(WAIT_W)) u_win (
      .clock     (clock),
      .reset_b   (reset_b),
      .cfg_we    (cfg_we && (cfg_addr[5:3] == 3'(i))),
      .cfg_field (cfg_addr[2:0]),
      .cfg_data  (cfg_data),
      .addr_lo   (addr[15:0]),
      .bank_zero (bank_zero),
      .rw        (rw),
      .match     (match[i]),
      .wait_cnt  (wait_all[i])
    );
  end

  logic [NUM_CS-1:0] win_sel;
  logic [WAIT_W-1:0] win_wait;
  logic              any_hit;
  logic              in_hole;
  logic              ram_hit;

  always_comb begin
    win_sel  = '0;
    win_wait = '0;
    any_hit  = 1'b0;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if (match[i]) begin
        win_sel    = '0;
        win_sel[i] = 1'b1;
        win_wait   = wait_all[i];
        any_hit    = 1'b1;
      end
    end
  end

  assign in_hole = bank_zero && ((addr[15:0] & IO_HOLE_MASK) == IO_HOLE_BASE);
  assign ram_hit = !any_hit && !in_hole;

  state_t            state;
  logic [WAIT_W-1:0] cnt;

  // In WAIT the select registers hold the latched channel; addr is ignored.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cs_b     <= '1;
      ram_cs_b <= 1'b1;
      rdy      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          cs_b     <= ~win_sel;
          ram_cs_b <= ~ram_hit;
          if (win_wait != '0) begin
            state <= ST_WAIT;
            cnt   <= win_wait;
            rdy   <= 1'b0;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - WAIT_W'(1);
          if (cnt == WAIT_W'(1)) begin
            rdy   <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adec_prog.sv
// Self-checking bench for adec_prog: directed scenarios followed by random
// traffic, all compared against a behavioural decoder/stall model.
module tb_adec_prog;

  logic        clock = 1'b0;
  logic        reset_b = 1'b0;
  logic [18:0] addr = '0;
  logic        rw = 1'b1;
  logic        cfg_we = 1'b0;
  logic [5:0]  cfg_addr = '0;
  logic [7:0]  cfg_data = '0;
  logic [5:0]  cs_b;
  logic        ram_cs_b;
  logic        rdy;

  int checks = 0;
  int errors = 0;

  adec_prog #(.NUM_CS(6), .ADDR_W(19), .WAIT_W(3)) dut (
    .clock    (clock),
    .reset_b  (reset_b),
    .addr     (addr),
    .rw       (rw),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cs_b     (cs_b),
    .ram_cs_b (ram_cs_b),
    .rdy      (rdy)
  );

  always #5 clock = ~clock;

  // Reference model: channel table, expected outputs, stall cycles remaining.
  logic [15:0] m_base [8];
  logic [15:0] m_mask [8];
  logic [7:0]  m_ctrl [8];
  logic [5:0]  e_cs;
  logic        e_ram;
  logic        e_rdy;
  int          m_hold;

  task automatic model_reset();
    m_base = '{16'hD400, 16'hDC00, 16'hDC10, 16'hDC20, 16'hDE00, 16'h0000, 16'h0000, 16'h0000};
    m_mask = '{16'hFC00, 16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFE00, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    m_ctrl = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
    e_cs = 6'h3F; e_ram = 1'b1; e_rdy = 1'b1; m_hold = 0;
  endtask

  function automatic void decode(input logic [18:0] a, input logic r,
                                 output logic [5:0] cs, output logic ram, output int w);
    bit found = 0;
    bit bank0 = (a[18:16] == 3'd0);
    cs = 6'h3F; ram = 1'b1; w = 0;
    for (int i = 0; i < 6; i++) begin
      if (!found && m_ctrl[i][7] && bank0 &&
          ((a[15:0] & m_mask[i]) == (m_base[i] & m_mask[i])) &&
          !(m_ctrl[i][6] && !r)) begin
        cs[i] = 1'b0;
        w = int'(m_ctrl[i][2:0]);
        found = 1;
      end
    end
    if (!found && !(bank0 && a[15:12] == 4'hD)) ram = 1'b0;
  endfunction

  task automatic model_edge();
    int w;
    if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) e_rdy = 1'b1;
    end else begin
      decode(addr, rw, e_cs, e_ram, w);
      if (w > 0) begin
        e_rdy = 1'b0;
        m_hold = w;
      end
    end
    if (cfg_we && cfg_addr[5:3] < 3'd6) begin
      case (cfg_addr[2:0])
        3'd0: m_base[cfg_addr[5:3]][7:0]  = cfg_data;
        3'd1: m_base[cfg_addr[5:3]][15:8] = cfg_data;
        3'd2: m_mask[cfg_addr[5:3]][7:0]  = cfg_data;
        3'd3: m_mask[cfg_addr[5:3]][15:8] = cfg_data;
        3'd4: m_ctrl[cfg_addr[5:3]]       = cfg_data;
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    chk("cs_b", 32'(cs_b), 32'(e_cs));
    chk("ram_cs_b", 32'(ram_cs_b), 32'(e_ram));
    chk("rdy", 32'(rdy), 32'(e_rdy));
    cfg_we = 1'b0;
  endtask

  task automatic cfg(input int ch, input int fld, input logic [7:0] d);
    cfg_we = 1'b1;
    cfg_addr = {3'(ch), 3'(fld)};
    cfg_data = d;
    tick();
  endtask

  task automatic access(input logic [18:0] a, input logic r);
    addr = a;
    rw = r;
    tick();
  endtask

  int rdy_low;
  int cs_low;

  initial begin
    model_reset();
    #12;
    chk("reset_cs_b", 32'(cs_b), 32'h3F);
    chk("reset_ram", 32'(ram_cs_b), 32'h1);
    chk("reset_rdy", 32'(rdy), 32'h1);
    @(negedge clock);
    reset_b = 1'b1;

    access(19'h0DC05, 1'b1);
    chk("dc05_via1", 32'(cs_b), 32'h3D);
    access(19'h01234, 1'b1);
    chk("ram_low", 32'(ram_cs_b), 32'h0);
    access(19'h1D400, 1'b1);
    chk("bank1_ram", 32'({cs_b, ram_cs_b}), 32'h7E);
    access(19'h0D000, 1'b1);
    chk("hole_none", 32'({cs_b, ram_cs_b}), 32'h7F);
    access(19'h0D7FF, 1'b1);
    chk("sid_top", 32'(cs_b), 32'h3E);

    cfg(4, 4, 8'h80);
    access(19'h0DF10, 1'b1);
    chk("bifrost_on", 32'(cs_b), 32'h2F);
    cfg(4, 3, 8'hFF);
    cfg(4, 2, 8'hFF);
    access(19'h0DF10, 1'b1);
    chk("bifrost_narrow_miss", 32'(cs_b), 32'h3F);
    access(19'h0DE00, 1'b1);
    chk("bifrost_narrow_hit", 32'(cs_b), 32'h2F);

    cfg(3, 4, 8'h83);
    rdy_low = 0;
    cs_low = 0;
    access(19'h0DC20, 1'b1);
    if (!rdy) rdy_low++;
    if (!cs_b[3]) cs_low++;
    addr = 19'h01000;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (!rdy) rdy_low++;
      if (!cs_b[3]) cs_low++;
    end
    chk("wait_rdy_cycles", 32'(rdy_low), 32'd3);
    chk("wait_cs_cycles", 32'(cs_low), 32'd4);
    chk("after_wait_ram", 32'(ram_cs_b), 32'h0);

    cfg(0, 4, 8'hC0);
    access(19'h0D400, 1'b0);
    chk("wp_write", 32'({cs_b, ram_cs_b}), 32'h7F);
    access(19'h0D400, 1'b1);
    chk("wp_read", 32'(cs_b), 32'h3E);
    cfg(5, 0, 8'h00);
    cfg(5, 1, 8'hDC);
    cfg(5, 2, 8'h00);
    cfg(5, 3, 8'hFF);
    cfg(5, 4, 8'h80);
    access(19'h0DC05, 1'b1);
    chk("priority_ch1", 32'(cs_b), 32'h3D);

    cfg(2, 4, 8'h87);
    access(19'h0DC10, 1'b1);
    tick();
    #2;
    reset_b = 1'b0;
    model_reset();
    #1;
    chk("async_rst_rdy", 32'(rdy), 32'h1);
    chk("async_rst_cs", 32'(cs_b), 32'h3F);
    @(negedge clock);
    reset_b = 1'b1;
    access(19'h0DC10, 1'b1);
    chk("ch2_ctrl_default", 32'({cs_b, rdy}), 32'h77);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(9) == 0) begin
        cfg_we = 1'b1;
        cfg_addr = 6'($urandom);
        cfg_data = 8'($urandom);
      end
      if ($urandom_range(2) != 0) addr = {3'd0, 4'hD, 12'($urandom)};
      else addr = 19'($urandom);
      rw = 1'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
